// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control encodings: ALUOp values, funct fields, ALU operation codes
// and the sequencing FSM state type.
package alu_ctrl_pkg;

  localparam logic [2:0] R_TYPE = 3'b111;
  localparam logic [2:0] ADDI   = 3'b100;
  localparam logic [2:0] ORI    = 3'b101;
  localparam logic [2:0] LUI    = 3'b011;

  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_MULT = 6'b011000;
  localparam logic [5:0] F_DIV  = 6'b011010;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;

  localparam logic [3:0] OP_AND     = 4'b0000;
  localparam logic [3:0] OP_OR      = 4'b0001;
  localparam logic [3:0] OP_NOR     = 4'b0010;
  localparam logic [3:0] OP_ADD     = 4'b0011;
  localparam logic [3:0] OP_SUB     = 4'b0100;
  localparam logic [3:0] OP_LUI     = 4'b0101;
  localparam logic [3:0] OP_SLT     = 4'b0110;
  localparam logic [3:0] OP_SLL     = 4'b0111;
  localparam logic [3:0] OP_SRL     = 4'b1000;
  localparam logic [3:0] OP_ILLEGAL = 4'b1001;
  localparam logic [3:0] OP_MULT    = 4'b1010;
  localparam logic [3:0] OP_DIV     = 4'b1011;
  localparam logic [3:0] OP_MFHI    = 4'b1100;
  localparam logic [3:0] OP_MFLO    = 4'b1101;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MDU_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/alu_control_mc_if.sv
// Upstream/downstream bundle of the multi-cycle ALU control.
// Handshake: an input transfers on a rising edge where in_valid & in_ready & ~flush;
// out_valid is a one-cycle pulse with no backpressure, and the upstream must hold
// in_valid/alu_op/alu_function stable until the transfer happens.
interface alu_control_mc_if #(
  parameter int ALUOP_WIDTH = 3,
  parameter int FUNCT_WIDTH = 6,
  parameter int OP_WIDTH    = 4
) ();
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [ALUOP_WIDTH-1:0] alu_op;
  logic [FUNCT_WIDTH-1:0] alu_function;
  logic                   out_valid;
  logic [OP_WIDTH-1:0]    alu_operation;
  logic                   illegal;
  logic                   mdu_start;
  logic                   mdu_is_div;
  logic                   stall;

  modport master (
    output flush, in_valid, alu_op, alu_function,
    input  in_ready, out_valid, alu_operation, illegal, mdu_start, mdu_is_div, stall
  );

  modport slave (
    input  flush, in_valid, alu_op, alu_function,
    output in_ready, out_valid, alu_operation, illegal, mdu_start, mdu_is_div, stall
  );
endinterface

// File: rtl/alu_control_mc_decode.sv
// Pure decode of {ALUOp, funct} into an ALU operation code plus MDU/illegal flags.
module alu_decode_comb
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_WIDTH = 3,
  parameter int FUNCT_WIDTH = 6
) (
  input  logic [ALUOP_WIDTH-1:0] i_alu_op,
  input  logic [FUNCT_WIDTH-1:0] i_funct,
  output logic [3:0]             o_code,
  output logic                   o_is_mdu,
  output logic                   o_is_div,
  output logic                   o_illegal
);

  always_comb begin
    o_code    = OP_ILLEGAL;
    o_is_mdu  = 1'b0;
    o_is_div  = 1'b0;
    o_illegal = 1'b0;
    case (i_alu_op)
      ALUOP_WIDTH'(R_TYPE): begin
        case (i_funct)
          FUNCT_WIDTH'(F_AND):  o_code = OP_AND;
          FUNCT_WIDTH'(F_OR):   o_code = OP_OR;
          FUNCT_WIDTH'(F_NOR):  o_code = OP_NOR;
          FUNCT_WIDTH'(F_ADD):  o_code = OP_ADD;
          FUNCT_WIDTH'(F_SUB):  o_code = OP_SUB;
          FUNCT_WIDTH'(F_SLT):  o_code = OP_SLT;
          FUNCT_WIDTH'(F_SLL):  o_code = OP_SLL;
          FUNCT_WIDTH'(F_SRL):  o_code = OP_SRL;
          FUNCT_WIDTH'(F_MFHI): o_code = OP_MFHI;
          FUNCT_WIDTH'(F_MFLO): o_code = OP_MFLO;
          FUNCT_WIDTH'(F_MULT): begin
            o_code   = OP_MULT;
            o_is_mdu = 1'b1;
          end
          FUNCT_WIDTH'(F_DIV): begin
            o_code   = OP_DIV;
            o_is_mdu = 1'b1;
            o_is_div = 1'b1;
          end
          default: o_illegal = 1'b1;
        endcase
      end
      // I-type encodings ignore the funct field entirely
      ALUOP_WIDTH'(ADDI): o_code = OP_ADD;
      ALUOP_WIDTH'(ORI):  o_code = OP_OR;
      ALUOP_WIDTH'(LUI):  o_code = OP_LUI;
      default:            o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_control_mc.sv
// Multi-cycle ALU control: registered decode for single-cycle ops, and a
// counter-driven FSM that launches MULT/DIV and stalls the front end until done.
module alu_control_mc
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_WIDTH = 3,
  parameter int FUNCT_WIDTH = 6,
  parameter int OP_WIDTH    = 4,
  parameter int MUL_CYCLES  = 32,
  parameter int DIV_CYCLES  = 32
) (
  input  logic   clk,
  input  logic   reset,
  alu_control_mc_if.slave bus,
  output state_e o_dbg_state
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  state_e              r_state;
  logic [CW-1:0]       r_count;
  logic                r_out_valid;
  logic                r_illegal;
  logic                r_mdu_start;
  logic                r_mdu_is_div;
  logic [OP_WIDTH-1:0] r_op;

  logic [3:0] w_code;
  logic       w_is_mdu;
  logic       w_is_div;
  logic       w_illegal;
  logic       w_accept;

  alu_decode_comb #(
    .ALUOP_WIDTH (ALUOP_WIDTH),
    .FUNCT_WIDTH (FUNCT_WIDTH)
  ) u_decode (
    .i_alu_op  (bus.alu_op),
    .i_funct   (bus.alu_function),
    .o_code    (w_code),
    .o_is_mdu  (w_is_mdu),
    .o_is_div  (w_is_div),
    .o_illegal (w_illegal)
  );

  assign w_accept = (r_state == ST_IDLE) && bus.in_valid && !bus.flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_out_valid  <= 1'b0;
      r_illegal    <= 1'b0;
      r_mdu_start  <= 1'b0;
      r_mdu_is_div <= 1'b0;
      r_op         <= OP_WIDTH'(OP_ILLEGAL);
    end else begin
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
      r_mdu_start <= 1'b0;
      if (bus.flush) begin
        r_state <= ST_IDLE;
        r_count <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              if (w_is_mdu) begin
                r_state      <= ST_MDU_BUSY;
                r_mdu_start  <= 1'b1;
                r_mdu_is_div <= w_is_div;
                r_count      <= w_is_div ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
              end else begin
                r_out_valid <= 1'b1;
                r_illegal   <= w_illegal;
                r_op        <= OP_WIDTH'(w_code);
              end
            end
          end
          ST_MDU_BUSY: begin
            // Result is announced on the edge after the counter reaches zero
            if (r_count == '0) begin
              r_state     <= ST_IDLE;
              r_out_valid <= 1'b1;
              r_op        <= r_mdu_is_div ? OP_WIDTH'(OP_DIV) : OP_WIDTH'(OP_MULT);
            end else begin
              r_count <= r_count - CW'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready      = (r_state == ST_IDLE);
  assign bus.stall         = (r_state == ST_MDU_BUSY);
  assign bus.out_valid     = r_out_valid;
  assign bus.illegal       = r_illegal;
  assign bus.mdu_start     = r_mdu_start;
  assign bus.mdu_is_div    = r_mdu_is_div;
  assign bus.alu_operation = r_op;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_alu_control_mc.sv
// Directed bench for alu_control_mc: decode table, MULT/DIV sequencing, flush and reset.
module tb_alu_control_mc;
  import alu_ctrl_pkg::*;

  logic   clk;
  logic   rst_a;
  logic   rst_b;
  state_e a_state;
  state_e b_state;

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_q[$];
  logic       mon_en = 1'b0;
  int         sb_seen = 0;

  alu_control_mc_if a_if ();
  alu_control_mc_if b_if ();

  alu_control_mc #(.MUL_CYCLES(32), .DIV_CYCLES(5)) dut_a (
    .clk         (clk),
    .reset       (rst_a),
    .bus         (a_if.slave),
    .o_dbg_state (a_state)
  );

  alu_control_mc #(.MUL_CYCLES(1), .DIV_CYCLES(1)) dut_b (
    .clk         (clk),
    .reset       (rst_b),
    .bus         (b_if.slave),
    .o_dbg_state (b_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_a(input logic v, input logic [2:0] op, input logic [5:0] fn);
    a_if.in_valid     = v;
    a_if.alu_op       = op;
    a_if.alu_function = fn;
  endtask

  task automatic drive_b(input logic v, input logic [2:0] op, input logic [5:0] fn);
    b_if.in_valid     = v;
    b_if.alu_op       = op;
    b_if.alu_function = fn;
  endtask

  task automatic sb_vec(input logic [2:0] op, input logic [5:0] fn,
                        input logic [3:0] code, input logic ill);
    drive_a(1'b1, op, fn);
    exp_q.push_back({ill, code});
    cyc();
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_in_ready"},  32'(a_if.in_ready),      32'd1);
    check({tag, "_out_valid"}, 32'(a_if.out_valid),     32'd0);
    check({tag, "_illegal"},   32'(a_if.illegal),       32'd0);
    check({tag, "_mdu_start"}, 32'(a_if.mdu_start),     32'd0);
    check({tag, "_is_div"},    32'(a_if.mdu_is_div),    32'd0);
    check({tag, "_stall"},     32'(a_if.stall),         32'd0);
    check({tag, "_op"},        32'(a_if.alu_operation), 32'h9);
    check({tag, "_state"},     32'(a_state),            32'(ST_IDLE));
  endtask

  // scoreboard monitor for the decode sweep
  always @(negedge clk) begin
    if (mon_en && a_if.out_valid) begin
      sb_seen++;
      if (exp_q.size() == 0) check("sb_extra_pulse", 32'd1, 32'd0);
      else check("sb_decode", 32'({a_if.illegal, a_if.alu_operation[3:0]}), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    int lat;
    int starts;
    int pulses;
    int stall_bad;

    rst_a = 1'b1;
    rst_b = 1'b1;
    a_if.flush = 1'b0;
    b_if.flush = 1'b0;
    drive_a(1'b0, 3'b000, 6'b000000);
    drive_b(1'b0, 3'b000, 6'b000000);
    @(negedge clk);
    cyc();
    check_reset_a("rst");
    rst_a = 1'b0;
    rst_b = 1'b0;
    cyc();

    // back-to-back ADD then OR
    drive_a(1'b1, R_TYPE, F_ADD);
    cyc();
    check("add_valid", 32'(a_if.out_valid), 32'd1);
    check("add_op", 32'(a_if.alu_operation), 32'(OP_ADD));
    check("add_ready", 32'(a_if.in_ready), 32'd1);
    check("add_ill", 32'(a_if.illegal), 32'd0);
    drive_a(1'b1, R_TYPE, F_OR);
    cyc();
    check("or_valid", 32'(a_if.out_valid), 32'd1);
    check("or_op", 32'(a_if.alu_operation), 32'(OP_OR));
    drive_a(1'b0, 3'b000, 6'b000000);
    cyc();
    check("idle_no_pulse", 32'(a_if.out_valid), 32'd0);
    check("op_holds", 32'(a_if.alu_operation), 32'(OP_OR));

    // decode sweep through the scoreboard
    mon_en = 1'b1;
    sb_vec(ADDI, 6'($urandom_range(0, 63)), OP_ADD, 1'b0);
    sb_vec(LUI, 6'($urandom_range(0, 63)), OP_LUI, 1'b0);
    sb_vec(3'b110, 6'b000000, OP_ILLEGAL, 1'b1);
    sb_vec(R_TYPE, F_AND, OP_AND, 1'b0);
    sb_vec(R_TYPE, F_NOR, OP_NOR, 1'b0);
    sb_vec(R_TYPE, F_SUB, OP_SUB, 1'b0);
    sb_vec(R_TYPE, F_SLT, OP_SLT, 1'b0);
    sb_vec(R_TYPE, F_SLL, OP_SLL, 1'b0);
    sb_vec(R_TYPE, F_SRL, OP_SRL, 1'b0);
    sb_vec(R_TYPE, F_MFHI, OP_MFHI, 1'b0);
    sb_vec(R_TYPE, F_MFLO, OP_MFLO, 1'b0);
    sb_vec(ORI, 6'($urandom_range(0, 63)), OP_OR, 1'b0);
    sb_vec(R_TYPE, 6'b111111, OP_ILLEGAL, 1'b1);
    sb_vec(3'b000, F_ADD, OP_ILLEGAL, 1'b1);
    drive_a(1'b0, 3'b000, 6'b000000);
    cyc();
    check("illegal_clears", 32'(a_if.illegal), 32'd0);
    mon_en = 1'b0;
    check("sb_pulses", 32'(sb_seen), 32'd14);
    check("sb_queue_empty", 32'(exp_q.size()), 32'd0);

    // MULT with 32-cycle latency, ADD held during the stall
    drive_a(1'b1, R_TYPE, F_MULT);
    cyc();
    check("mult_start", 32'(a_if.mdu_start), 32'd1);
    check("mult_is_div", 32'(a_if.mdu_is_div), 32'd0);
    check("mult_stall", 32'(a_if.stall), 32'd1);
    check("mult_ready", 32'(a_if.in_ready), 32'd0);
    check("mult_state", 32'(a_state), 32'(ST_MDU_BUSY));
    check("mult_no_valid", 32'(a_if.out_valid), 32'd0);
    drive_a(1'b1, R_TYPE, F_ADD);
    lat = 0;
    starts = 0;
    stall_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      if (a_if.out_valid) begin
        lat = k;
        break;
      end
      if (a_if.mdu_start) starts++;
      if (!a_if.stall) stall_bad++;
    end
    check("mult_latency", 32'(lat), 32'd32);
    check("mult_op", 32'(a_if.alu_operation), 32'(OP_MULT));
    check("mult_stall_held", 32'(stall_bad), 32'd0);
    check("mult_single_start", 32'(starts), 32'd0);
    check("mult_done_stall", 32'(a_if.stall), 32'd0);
    check("mult_done_ready", 32'(a_if.in_ready), 32'd1);
    cyc();
    check("held_add_valid", 32'(a_if.out_valid), 32'd1);
    check("held_add_op", 32'(a_if.alu_operation), 32'(OP_ADD));
    drive_a(1'b0, 3'b000, 6'b000000);
    cyc();
    check("held_add_once", 32'(a_if.out_valid), 32'd0);

    // DIV with flush two cycles into MDU_BUSY
    drive_a(1'b1, R_TYPE, F_DIV);
    cyc();
    check("div_start", 32'(a_if.mdu_start), 32'd1);
    check("div_is_div", 32'(a_if.mdu_is_div), 32'd1);
    drive_a(1'b0, 3'b000, 6'b000000);
    cyc();
    a_if.flush = 1'b1;
    cyc();
    a_if.flush = 1'b0;
    check("flush_ready", 32'(a_if.in_ready), 32'd1);
    check("flush_stall", 32'(a_if.stall), 32'd0);
    check("flush_state", 32'(a_state), 32'(ST_IDLE));
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (a_if.out_valid) pulses++;
      cyc();
    end
    check("flush_no_result", 32'(pulses), 32'd0);
    drive_a(1'b1, R_TYPE, F_SUB);
    cyc();
    check("sub_valid", 32'(a_if.out_valid), 32'd1);
    check("sub_op", 32'(a_if.alu_operation), 32'(OP_SUB));
    // flush beats a simultaneous input
    a_if.flush = 1'b1;
    drive_a(1'b1, R_TYPE, F_AND);
    cyc();
    check("flush_wins_valid", 32'(a_if.out_valid), 32'd0);
    check("flush_wins_op", 32'(a_if.alu_operation), 32'(OP_SUB));
    a_if.flush = 1'b0;
    drive_a(1'b0, 3'b000, 6'b000000);
    cyc();

    // reset mid-MULT together with an ADD
    drive_a(1'b1, R_TYPE, F_MULT);
    cyc();
    drive_a(1'b0, 3'b000, 6'b000000);
    cyc();
    cyc();
    rst_a = 1'b1;
    drive_a(1'b1, R_TYPE, F_ADD);
    cyc();
    check_reset_a("midrst");
    rst_a = 1'b0;
    drive_a(1'b0, 3'b000, 6'b000000);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (a_if.out_valid) pulses++;
    end
    check("midrst_no_pulse", 32'(pulses), 32'd0);

    // single-cycle MDU latency: MULT then MFLO
    drive_b(1'b1, R_TYPE, F_MULT);
    cyc();
    check("b_start", 32'(b_if.mdu_start), 32'd1);
    check("b_stall", 32'(b_if.stall), 32'd1);
    check("b_no_valid", 32'(b_if.out_valid), 32'd0);
    drive_b(1'b1, R_TYPE, F_MFLO);
    cyc();
    check("b_mult_valid", 32'(b_if.out_valid), 32'd1);
    check("b_mult_op", 32'(b_if.alu_operation), 32'(OP_MULT));
    check("b_ready", 32'(b_if.in_ready), 32'd1);
    check("b_start_pulse", 32'(b_if.mdu_start), 32'd0);
    cyc();
    check("b_mflo_valid", 32'(b_if.out_valid), 32'd1);
    check("b_mflo_op", 32'(b_if.alu_operation), 32'(OP_MFLO));
    drive_b(1'b0, 3'b000, 6'b000000);
    cyc();
    check("b_idle", 32'(b_if.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
